// File: rtl/c_demux_3_buf.sv
// c_demux_3_buf: 1-to-8 buffered demultiplexer with one-entry holding
// register and valid/ready handshake per output channel.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   sel        destination channel index (0..7)
//   in         input data word
//   in_valid   producer presents a word this cycle
//   in_ready   selected channel can accept this cycle (combinational)
//   out0..7    held data of channels 0..7
//   out_valid  bit i = channel i holds an unconsumed word
//   out_ready  bit i = consumer i takes out_i this cycle
//   busy       OR of out_valid
//   xfer_count accepted input transfers, wraps modulo 256
module c_demux_3_buf #(
    parameter int BITS = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [2:0]      sel,
    input  logic [BITS-1:0] in,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [BITS-1:0] out0,
    output logic [BITS-1:0] out1,
    output logic [BITS-1:0] out2,
    output logic [BITS-1:0] out3,
    output logic [BITS-1:0] out4,
    output logic [BITS-1:0] out5,
    output logic [BITS-1:0] out6,
    output logic [BITS-1:0] out7,
    output logic [7:0]      out_valid,
    input  logic [7:0]      out_ready,
    output logic            busy,
    output logic [7:0]      xfer_count
);

    logic [BITS-1:0] hold [8];
    logic [2:0]      idx;
    logic            accept;

    // Unknown select bits fall through to channel 0, like the 8:1 mux.
    always_comb begin
        idx = 3'd0;
        case (sel)
            3'd0:    idx = 3'd0;
            3'd1:    idx = 3'd1;
            3'd2:    idx = 3'd2;
            3'd3:    idx = 3'd3;
            3'd4:    idx = 3'd4;
            3'd5:    idx = 3'd5;
            3'd6:    idx = 3'd6;
            3'd7:    idx = 3'd7;
            default: idx = 3'd0;
        endcase
    end

    // A full channel can still accept when its consumer pops this cycle,
    // giving one word per cycle per channel.
    assign in_ready = !out_valid[idx] || out_ready[idx];
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 8'h00;
            xfer_count <= 8'h00;
            for (int i = 0; i < 8; i++) begin
                hold[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (accept && (idx == 3'(i))) begin
                    hold[i]      <= in;
                    out_valid[i] <= 1'b1;
                end else if (out_valid[i] && out_ready[i]) begin
                    out_valid[i] <= 1'b0;
                end
            end
            if (accept) begin
                xfer_count <= xfer_count + 8'd1;
            end
        end
    end

    assign busy = |out_valid;

    assign out0 = hold[0];
    assign out1 = hold[1];
    assign out2 = hold[2];
    assign out3 = hold[3];
    assign out4 = hold[4];
    assign out5 = hold[5];
    assign out6 = hold[6];
    assign out7 = hold[7];

endmodule

// File: tb/tb_c_demux_3_buf.sv
// tb_c_demux_3_buf: scoreboard bench for c_demux_3_buf (BITS=8).
// Stimulus pushes expected words per channel; a monitor checks pops.
module tb_c_demux_3_buf;

    logic       clk;
    logic       reset;
    logic [2:0] sel;
    logic [7:0] in;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] o [8];
    logic [7:0] out_valid;
    logic [7:0] out_ready;
    logic       busy;
    logic [7:0] xfer_count;

    int errors = 0;
    int checks = 0;

    logic [7:0] sbq [8][$];

    c_demux_3_buf #(.BITS(8)) dut (
        .clk(clk),
        .reset(reset),
        .sel(sel),
        .in(in),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out0(o[0]),
        .out1(o[1]),
        .out2(o[2]),
        .out3(o[3]),
        .out4(o[4]),
        .out5(o[5]),
        .out6(o[6]),
        .out7(o[7]),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy(busy),
        .xfer_count(xfer_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int ch, input logic [7:0] d);
        sbq[ch].push_back(d);
    endtask

    // Monitor: whenever a consumer takes a word, compare it to the
    // oldest expected word for that channel.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            for (int i = 0; i < 8; i++) begin
                if (out_valid[i] && out_ready[i]) begin
                    if (sbq[i].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL pop_ch%0d: got %0h expected none",
                                 i, o[i]);
                    end else begin
                        chk($sformatf("pop_ch%0d", i), 32'(o[i]),
                            32'(sbq[i].pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] start_cnt;
        int left;

        reset     = 1'b1;
        in_valid  = 1'b1;
        sel       = 3'd3;
        in        = 8'hEE;
        out_ready = 8'h00;

        // reset with a pending accept
        tick();
        tick();
        @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'h00);
        chk("rst_count", 32'(xfer_count), 32'h00);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_out3", 32'(o[3]), 32'h00);

        // single route
        tick();
        reset    = 1'b0;
        sel      = 3'd5;
        in       = 8'hA5;
        in_valid = 1'b1;
        push(5, 8'hA5);
        @(negedge clk);
        chk("route_ready", 32'(in_ready), 32'h1);
        tick();
        in_valid  = 1'b0;
        out_ready = 8'h20;
        @(negedge clk);
        chk("route_valid", 32'(out_valid), 32'h20);
        chk("route_out5", 32'(o[5]), 32'hA5);
        chk("route_busy", 32'(busy), 32'h1);
        chk("route_count", 32'(xfer_count), 32'h01);
        tick();
        out_ready = 8'h00;
        @(negedge clk);
        chk("pop_valid", 32'(out_valid), 32'h00);
        chk("pop_hold5", 32'(o[5]), 32'hA5);
        chk("pop_busy", 32'(busy), 32'h0);

        // backpressure on channel 2
        tick();
        sel      = 3'd2;
        in       = 8'h22;
        in_valid = 1'b1;
        push(2, 8'h22);
        tick();
        in = 8'h11;
        @(negedge clk);
        chk("bp_ready0", 32'(in_ready), 32'h0);
        chk("bp_out2", 32'(o[2]), 32'h22);
        chk("bp_valid", 32'(out_valid), 32'h04);
        tick();
        @(negedge clk);
        chk("bp_hold_ready", 32'(in_ready), 32'h0);
        chk("bp_hold_out2", 32'(o[2]), 32'h22);
        tick();
        out_ready = 8'h04;
        push(2, 8'h11);
        @(negedge clk);
        chk("bp_ready1", 32'(in_ready), 32'h1);
        tick();
        in_valid  = 1'b0;
        out_ready = 8'h00;
        @(negedge clk);
        chk("bp_out2_new", 32'(o[2]), 32'h11);
        chk("bp_valid_kept", 32'(out_valid), 32'h04);
        chk("bp_count", 32'(xfer_count), 32'h03);
        tick();
        out_ready = 8'h04;
        tick();
        out_ready = 8'h00;
        @(negedge clk);
        chk("bp_drained", 32'(out_valid), 32'h00);

        // parallel fill of all eight channels
        for (int i = 0; i < 8; i++) begin
            tick();
            sel      = 3'(i);
            in       = 8'h10 + 8'(i);
            in_valid = 1'b1;
            push(i, 8'h10 + 8'(i));
            @(negedge clk);
            chk($sformatf("fill_ready%0d", i), 32'(in_ready), 32'h1);
        end
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("fill_valid", 32'(out_valid), 32'hFF);
        chk("fill_count", 32'(xfer_count), 32'h0B);
        chk("fill_out0", 32'(o[0]), 32'h10);
        chk("fill_out7", 32'(o[7]), 32'h17);
        tick();
        out_ready = 8'hFF;
        tick();
        out_ready = 8'h00;
        @(negedge clk);
        chk("fill_drained", 32'(out_valid), 32'h00);

        // 256 back-to-back accepts to channel 7 with wrap
        start_cnt = xfer_count;
        tick();
        out_ready = 8'h80;
        sel       = 3'd7;
        in_valid  = 1'b1;
        for (int k = 0; k < 256; k++) begin
            in = 8'(k);
            push(7, 8'(k));
            @(negedge clk);
            chk($sformatf("stream_ready%0d", k), 32'(in_ready), 32'h1);
            tick();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("stream_count", 32'(xfer_count), 32'(start_cnt));
        chk("stream_out7", 32'(o[7]), 32'hFF);
        tick();
        out_ready = 8'h00;
        @(negedge clk);
        chk("stream_drained", 32'(out_valid), 32'h00);

        // reset while holding words and with an accept pending
        for (int c = 1; c < 8; c++) begin
            if (c == 1 || c == 3 || c == 4 || c == 6) begin
                tick();
                sel      = 3'(c);
                in       = 8'h30 + 8'(c);
                in_valid = 1'b1;
                push(c, 8'h30 + 8'(c));
            end
        end
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_valid", 32'(out_valid), 32'h5A);
        tick();
        reset     = 1'b1;
        sel       = 3'd0;
        in        = 8'h99;
        in_valid  = 1'b1;
        out_ready = 8'hFF;
        for (int i = 0; i < 8; i++) sbq[i].delete();
        tick();
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 8'h00;
        @(negedge clk);
        chk("mid_rst_valid", 32'(out_valid), 32'h00);
        chk("mid_rst_count", 32'(xfer_count), 32'h00);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_out1", 32'(o[1]), 32'h00);
        chk("mid_rst_out0", 32'(o[0]), 32'h00);

        left = 0;
        for (int i = 0; i < 8; i++) left += sbq[i].size();
        chk("sb_empty", 32'(left), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/c_demux_3_buf.md
Name: c_demux_3_buf

Overview:
1-to-8 buffered demultiplexer, the write-side counterpart of the 3-bit select 8:1 mux. It steers one input word into one of eight per-channel one-entry holding registers, chosen by a 3-bit select. Each register presents valid/ready to its consumer. Used where a single producer (e.g. writeback or bus response) fans out to eight destinations that may stall independently.

Parameters:
BITS, 1, data width of the input word and of each output channel.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  synchronous, active-high reset.
sel  input  3  destination channel index for the current input word.
in  input  BITS  input data word.
in_valid  input  1  producer presents a word this cycle.
in_ready  output  1  selected channel can accept this cycle.
out0 .. out7  output  BITS each  held data of channels 0..7.
out_valid  output  8  bit i set = channel i holds an unconsumed word.
out_ready  input  8  bit i set = consumer i takes out_i this cycle.
busy  output  1  OR of out_valid.
xfer_count  output  8  count of accepted input transfers, wraps modulo 256.

Behaviour:
- Reset (sampled on clk edge while reset=1): out_valid=8'h00, out0..out7=0, xfer_count=0, busy=0. Reset overrides any same-cycle accept or pop. Reset mid-operation discards all held words.
- Channel index: sel 3'b000..3'b111 selects channel 0..7. Any non-0/1 sel bit (X/Z in sim) is treated as channel 0, matching the mux default.
- in_ready (combinational) = !out_valid[sel] || out_ready[sel]. This is a combinational path from out_ready and sel to in_ready; it is intentional and gives full throughput per channel.
- Accept: in_valid && in_ready at the clk edge loads in into channel sel and sets out_valid[sel]=1. Latency is 1 cycle: the word is visible on out_sel and out_valid in the cycle after the accepting edge.
- Pop: out_valid[i] && out_ready[i] at the clk edge clears out_valid[i], unless channel i is loaded on the same edge.
- Same-channel accept and pop on one edge: the old word is consumed, the new word is loaded, and out_valid[i] stays 1.
- out_ready[i] while out_valid[i]=0: ignored, no state change.
- in_valid=1 with in_ready=0: no state change. The producer must hold in, sel and in_valid stable until accepted.
- Channels not selected are unaffected by accepts. Pops on different channels occur independently and concurrently; all eight can pop on the same edge.
- Data holding: out_i keeps its last loaded value after a pop. It changes only on a load to channel i or on reset.
- xfer_count increments by 1 on every accept and wraps 8'hFF -> 8'h00.
- busy = |out_valid, derived combinationally from the registered out_valid bits.
- No internal FSM beyond the eight independent 2-state channels (EMPTY: out_valid=0; FULL: out_valid=1).
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on pop without accept.
  - FULL -> FULL on accept+pop, or on no pop.

Test Plan:
- Reset: drive reset=1 for 2 cycles with in_valid=1, sel=3 -> out_valid=00, xfer_count=0, busy=0, out3=0.
- Single route: BITS=8, sel=5, in=8'hA5, in_valid=1 for 1 cycle, out_ready=0 -> next cycle out_valid=8'h20, out5=A5, busy=1, xfer_count=1. Then out_ready[5]=1 for 1 cycle -> out_valid=00 while out5 stays A5.
- Backpressure: channel 2 full, out_ready[2]=0, in_valid=1 sel=2 in=8'h11 -> in_ready=0 and out2 unchanged. Raise out_ready[2] -> in_ready=1 in the same cycle; after the edge out2=11 and out_valid[2] stays 1.
- Parallel fill: write 8'h10..8'h17 to sel 0..7 on consecutive cycles with all out_ready=0 -> out_valid=FF, out_i=8'h10+i, xfer_count=8. Then out_ready=FF for 1 cycle -> out_valid=00.
- Wrap and throughput: stream 256 accepts to sel=7 with out_ready[7]=1 every cycle -> in_ready stays 1 throughout, xfer_count returns to 0, out7 equals the last word.
- Reset mid-stream: assert reset with out_valid=8'h5A and an accept pending -> next cycle out_valid=00 and xfer_count=0.
